// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between the fetch (I) and
// memory (D) stages, with a per-grant wait timeout reported on bus_err.
module mem_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_f,
    output logic        stall_m,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);
    state_t     state;
    logic       lastGrant;
    logic [7:0] waitCnt;
    logic       iElig, dElig, pickD, pickI, finish;
    // A port finishing this cycle sits out one arbitration round.
    assign iElig   = i_req & ~i_ready;
    assign dElig   = d_req & ~d_ready;
    assign pickD   = dElig & (~iElig | ~lastGrant);
    assign pickI   = iElig & ~pickD;
    assign finish  = mem_ack | (waitCnt == LAST_WAIT);
    assign stall_f = i_req & ~i_ready;
    assign stall_m = d_req & ~d_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lastGrant <= 1'b0;
            waitCnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            bus_err <= 1'b0;
            if (state == IDLE) begin
                if (pickD | pickI) begin
                    state     <= pickD ? GNT_D : GNT_I;
                    mem_req   <= 1'b1;
                    mem_we    <= pickD & d_we;
                    mem_addr  <= pickD ? d_addr : i_addr;
                    mem_wdata <= pickD ? d_wdata : '0;
                    mem_be    <= pickD ? d_be : 4'hF;
                    waitCnt   <= '0;
                end
            end else if (finish) begin
                // An ack on the timeout edge still counts as a normal completion.
                state     <= IDLE;
                mem_req   <= 1'b0;
                bus_err   <= ~mem_ack;
                lastGrant <= (state == GNT_D);
                if (state == GNT_D) begin
                    d_ready <= 1'b1;
                    if (!(mem_ack && mem_we)) d_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    i_ready <= 1'b1;
                    i_rdata <= mem_ack ? mem_rdata : '0;
                end
            end else begin
                waitCnt <= waitCnt + 8'd1;
            end
        end
    end
endmodule
